// File: rtl/legv8_pkg.sv
// Shared LEGv8 encoding definitions: op classes, opcode constants and field positions.
// The opcode constants are also consumed by the control decoder.
package legv8_pkg;

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_AND   = 4'd2,
        OP_ORR   = 4'd3,
        OP_EOR   = 4'd4,
        OP_LSL   = 4'd5,
        OP_LSR   = 4'd6,
        OP_LDUR  = 4'd7,
        OP_STUR  = 4'd8,
        OP_BR    = 4'd9,
        OP_CBZ   = 4'd10,
        OP_CBNZ  = 4'd11,
        OP_B     = 4'd12,
        OP_BL    = 4'd13,
        OP_RSV14 = 4'd14,
        OP_RSV15 = 4'd15
    } op_t;

    typedef enum logic {
        ST_IDLE,
        ST_PAD
    } state_t;

    localparam logic [10:0] OPC_ADD  = 11'b10001011000;
    localparam logic [10:0] OPC_SUB  = 11'b11001011000;
    localparam logic [10:0] OPC_AND  = 11'b10001010000;
    localparam logic [10:0] OPC_ORR  = 11'b10101010000;
    localparam logic [10:0] OPC_EOR  = 11'b11001010000;
    localparam logic [10:0] OPC_LSL  = 11'b11010011011;
    localparam logic [10:0] OPC_LSR  = 11'b11010011010;
    localparam logic [10:0] OPC_LDUR = 11'b11111000010;
    localparam logic [10:0] OPC_STUR = 11'b11111000000;
    localparam logic [10:0] OPC_BR   = 11'b11010110000;
    localparam logic [7:0]  OPC_CBZ  = 8'b10110100;
    localparam logic [7:0]  OPC_CBNZ = 8'b10110101;
    localparam logic [5:0]  OPC_B    = 6'b000101;
    localparam logic [5:0]  OPC_BL   = 6'b100101;

    // ADD XZR, XZR, XZR
    localparam logic [31:0] NOP_WORD = 32'h8B1F03FF;

    localparam int OPC11_LSB  = 21;
    localparam int OPC8_LSB   = 24;
    localparam int OPC6_LSB   = 26;
    localparam int RM_LSB     = 16;
    localparam int SHAMT_LSB  = 10;
    localparam int DADDR_LSB  = 12;
    localparam int CBADDR_LSB = 5;
    localparam int RN_LSB     = 5;
    localparam int RD_LSB     = 0;

    function automatic logic is_branch(input op_t op);
        return (op == OP_BR) || (op == OP_CBZ) || (op == OP_CBNZ) ||
               (op == OP_B)  || (op == OP_BL);
    endfunction

endpackage

// File: rtl/instr_field_pack.sv
// Combinational LEGv8 word packer: op class plus register/immediate fields to a 32-bit word,
// with range and illegal-op flags. Out-of-range immediates are truncated to the field width.
module instr_field_pack
    import legv8_pkg::*;
(
    input  op_t                op,
    input  logic [4:0]         rd,
    input  logic [4:0]         rn,
    input  logic [4:0]         rm,
    input  logic signed [25:0] imm,
    output logic [31:0]        word,
    output logic               range_err,
    output logic               illegal
);

    function automatic logic fits_s9(input logic signed [25:0] v);
        return (v >= -26'sd256) && (v <= 26'sd255);
    endfunction

    function automatic logic fits_s19(input logic signed [25:0] v);
        return (v >= -26'sd262144) && (v <= 26'sd262143);
    endfunction

    function automatic logic [31:0] pack_r(input logic [10:0] opc, input logic [4:0] f_rm,
                                           input logic [5:0] shamt, input logic [4:0] f_rn,
                                           input logic [4:0] f_rd);
        return (32'(opc) << OPC11_LSB) | (32'(f_rm) << RM_LSB) | (32'(shamt) << SHAMT_LSB) |
               (32'(f_rn) << RN_LSB) | (32'(f_rd) << RD_LSB);
    endfunction

    function automatic logic [31:0] pack_d(input logic [10:0] opc, input logic [8:0] imm9,
                                           input logic [4:0] f_rn, input logic [4:0] f_rt);
        return (32'(opc) << OPC11_LSB) | (32'(imm9) << DADDR_LSB) |
               (32'(f_rn) << RN_LSB) | (32'(f_rt) << RD_LSB);
    endfunction

    function automatic logic [31:0] pack_cb(input logic [7:0] opc, input logic [18:0] imm19,
                                            input logic [4:0] f_rt);
        return (32'(opc) << OPC8_LSB) | (32'(imm19) << CBADDR_LSB) | (32'(f_rt) << RD_LSB);
    endfunction

    function automatic logic [31:0] pack_b(input logic [5:0] opc, input logic [25:0] imm26);
        return (32'(opc) << OPC6_LSB) | 32'(imm26);
    endfunction

    always_comb begin
        word      = '0;
        range_err = 1'b0;
        illegal   = 1'b0;
        case (op)
            OP_ADD:  word = pack_r(OPC_ADD, rm, 6'd0, rn, rd);
            OP_SUB:  word = pack_r(OPC_SUB, rm, 6'd0, rn, rd);
            OP_AND:  word = pack_r(OPC_AND, rm, 6'd0, rn, rd);
            OP_ORR:  word = pack_r(OPC_ORR, rm, 6'd0, rn, rd);
            OP_EOR:  word = pack_r(OPC_EOR, rm, 6'd0, rn, rd);
            // Shift amount is an unsigned 6-bit field; any bit above it is out of range
            OP_LSL: begin
                word      = pack_r(OPC_LSL, 5'd0, imm[5:0], rn, rd);
                range_err = |imm[25:6];
            end
            OP_LSR: begin
                word      = pack_r(OPC_LSR, 5'd0, imm[5:0], rn, rd);
                range_err = |imm[25:6];
            end
            OP_LDUR: begin
                word      = pack_d(OPC_LDUR, imm[8:0], rn, rd);
                range_err = !fits_s9(imm);
            end
            OP_STUR: begin
                word      = pack_d(OPC_STUR, imm[8:0], rn, rd);
                range_err = !fits_s9(imm);
            end
            OP_BR:   word = pack_r(OPC_BR, 5'd0, 6'd0, rn, 5'd0);
            OP_CBZ: begin
                word      = pack_cb(OPC_CBZ, imm[18:0], rd);
                range_err = !fits_s19(imm);
            end
            OP_CBNZ: begin
                word      = pack_cb(OPC_CBNZ, imm[18:0], rd);
                range_err = !fits_s19(imm);
            end
            OP_B:    word = pack_b(OPC_B, imm[25:0]);
            OP_BL:   word = pack_b(OPC_BL, imm[25:0]);
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Streaming LEGv8 instruction encoder: one-deep output register with address counter,
// and NOP fill slots after every branch so the downstream core never needs a flush.
module instr_encoder
    import legv8_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0,
    parameter int BR_PAD    = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rn,
    input  logic [4:0]        in_rm,
    input  logic [25:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err_illegal,
    output logic              err_range
);

    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(4);
    localparam logic [3:0]        PAD_LOAD  = 4'(BR_PAD);

    op_t         op_p0;
    logic [31:0] word_p0;
    logic        range_p0;
    logic        illegal_p0;

    assign op_p0 = op_t'(in_op);

    instr_field_pack u_pack (
        .op        (op_p0),
        .rd        (in_rd),
        .rn        (in_rn),
        .rm        (in_rm),
        .imm       ($signed(in_imm)),
        .word      (word_p0),
        .range_err (range_p0),
        .illegal   (illegal_p0)
    );

    state_t      state;
    state_t      state_next;
    logic [3:0]  pad_cnt;
    logic [3:0]  pad_next;
    logic        slot_free;
    logic        handshake;
    logic        accept;
    logic        load;
    logic [31:0] load_word;

    // The output register may be refilled when empty or when its word leaves this cycle
    assign slot_free = !out_valid || out_ready;
    assign handshake = out_valid && out_ready;

    always_comb begin
        state_next = state;
        pad_next   = pad_cnt;
        in_ready   = 1'b0;
        accept     = 1'b0;
        load       = 1'b0;
        load_word  = word_p0;
        case (state)
            ST_IDLE: begin
                in_ready = slot_free;
                accept   = in_valid && slot_free;
                if (accept && !illegal_p0) begin
                    load = 1'b1;
                    if (is_branch(op_p0) && (PAD_LOAD != 4'd0)) begin
                        state_next = ST_PAD;
                        pad_next   = PAD_LOAD;
                    end
                end
            end
            ST_PAD: begin
                if (slot_free) begin
                    load      = 1'b1;
                    load_word = NOP_WORD;
                    pad_next  = pad_cnt - 4'd1;
                    if (pad_cnt == 4'd1) begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            pad_cnt <= 4'd0;
        end else begin
            state   <= state_next;
            pad_cnt <= pad_next;
        end
    end

    // Output stage: word register, address counter and sticky error flags
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid   <= 1'b0;
            out_instr   <= '0;
            out_addr    <= BASE;
            err_illegal <= 1'b0;
            err_range   <= 1'b0;
        end else begin
            if (load) begin
                out_valid <= 1'b1;
                out_instr <= load_word;
            end else if (handshake) begin
                out_valid <= 1'b0;
            end
            if (handshake) begin
                out_addr <= out_addr + ADDR_STEP;
            end
            if (accept && illegal_p0) begin
                err_illegal <= 1'b1;
            end
            if (accept && !illegal_p0 && range_p0) begin
                err_range <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed steps then random traffic, checked against a queue-based
// model of pending output words built from the LEGv8 field rules.
module tb_instr_encoder;

    localparam int AW  = 10;
    localparam int AWS = 4;
    localparam int PAD = 3;
    localparam logic [31:0] NOP = 32'h8B1F03FF;

    logic clock = 1'b0;
    logic reset;
    logic in_valid;
    logic out_ready;
    logic [3:0]  in_op;
    logic [4:0]  in_rd, in_rn, in_rm;
    logic [25:0] in_imm;

    logic in_ready, out_valid, err_illegal, err_range;
    logic [31:0] out_instr;
    logic [AW-1:0] out_addr;

    logic s_in_ready, s_out_valid, s_err_illegal, s_err_range;
    logic [31:0] s_out_instr;
    logic [AWS-1:0] s_out_addr;

    instr_encoder #(.ADDR_W(AW), .BASE_ADDR(0), .BR_PAD(PAD)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rd(in_rd), .in_rn(in_rn), .in_rm(in_rm), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_addr(out_addr), .err_illegal(err_illegal), .err_range(err_range)
    );

    // Same traffic into a 4-bit address space to exercise wrap-around
    instr_encoder #(.ADDR_W(AWS), .BASE_ADDR(0), .BR_PAD(PAD)) dut_s (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_op(in_op), .in_rd(in_rd), .in_rn(in_rn), .in_rm(in_rm), .in_imm(in_imm),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_instr(s_out_instr),
        .out_addr(s_out_addr), .err_illegal(s_err_illegal), .err_range(s_err_range)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad = 0;
    logic [31:0] exp_q[$];
    int exp_addr = 0;
    int exp_addr_s = 0;
    bit exp_ill = 0;
    bit exp_rng = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic longint fmod(input longint v, input longint m);
        return ((v % m) + m) % m;
    endfunction

    // Reference encoding from the op-class table, with plain integer arithmetic
    function automatic void ref_encode(input int op, input int rd, input int rn, input int rm,
                                       input logic [25:0] imm, output logic [31:0] w,
                                       output bit rng, output bit ill);
        longint s, u, x, opc;
        s = longint'($signed(imm));
        u = longint'(imm);
        x = 0; rng = 0; ill = 0;
        case (op)
            0, 1, 2, 3, 4: begin
                opc = (op == 0) ? 'b10001011000 : (op == 1) ? 'b11001011000 :
                      (op == 2) ? 'b10001010000 : (op == 3) ? 'b10101010000 : 'b11001010000;
                x = opc * 2097152 + rm * 65536 + rn * 32 + rd;
            end
            5, 6: begin
                opc = (op == 5) ? 'b11010011011 : 'b11010011010;
                x = opc * 2097152 + (u % 64) * 1024 + rn * 32 + rd;
                rng = (u > 63);
            end
            7, 8: begin
                opc = (op == 7) ? 'b11111000010 : 'b11111000000;
                x = opc * 2097152 + fmod(s, 512) * 4096 + rn * 32 + rd;
                rng = (s < -256) || (s > 255);
            end
            9: x = 'b11010110000 * 2097152 + rn * 32;
            10, 11: begin
                opc = (op == 10) ? 'b10110100 : 'b10110101;
                x = opc * 16777216 + fmod(s, 524288) * 32 + rd;
                rng = (s < -262144) || (s > 262143);
            end
            12, 13: begin
                opc = (op == 12) ? 'b000101 : 'b100101;
                x = opc * 67108864 + u;
            end
            default: ill = 1;
        endcase
        w = 32'(x);
    endfunction

    // One clock: check state against the model at the falling edge, then advance the model
    task automatic cycle(output bit acc);
        logic [31:0] w;
        bit rng, ill, hs, rdy;
        @(negedge clock);
        rdy = (exp_q.size() == 0) || (exp_q.size() == 1 && out_ready);
        chk("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
        chk("in_ready", 32'(in_ready), 32'(rdy));
        chk("err_illegal", 32'(err_illegal), 32'(exp_ill));
        chk("err_range", 32'(err_range), 32'(exp_rng));
        if (exp_q.size() > 0) begin
            chk("out_instr", out_instr, exp_q[0]);
            chk("out_addr", 32'(out_addr), 32'(exp_addr));
            chk("s_out_instr", s_out_instr, exp_q[0]);
            chk("s_out_addr", 32'(s_out_addr), 32'(exp_addr_s));
        end
        acc = in_valid && rdy;
        hs = (exp_q.size() > 0) && out_ready;
        if (hs) begin
            void'(exp_q.pop_front());
            exp_addr   = (exp_addr + 4) % (1 << AW);
            exp_addr_s = (exp_addr_s + 4) % (1 << AWS);
        end
        if (acc) begin
            ref_encode(int'(in_op), int'(in_rd), int'(in_rn), int'(in_rm), in_imm, w, rng, ill);
            if (ill) begin
                exp_ill = 1;
            end else begin
                exp_q.push_back(w);
                if (rng) exp_rng = 1;
                if (in_op >= 4'd9 && in_op <= 4'd13) begin
                    repeat (PAD) exp_q.push_back(NOP);
                end
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        bit acc;
        repeat (n) cycle(acc);
    endtask

    task automatic send(input int op, input int rd, input int rn, input int rm, input int imm);
        bit acc = 0;
        in_valid = 1'b1;
        in_op = 4'(op); in_rd = 5'(rd); in_rn = 5'(rn); in_rm = 5'(rm); in_imm = 26'(imm);
        for (int i = 0; i < 50; i++) begin
            cycle(acc);
            if (acc) break;
        end
        chk("send_accept_timeout", 32'(acc), 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_out_addr"}, 32'(out_addr), 32'd0);
        chk({tag, "_out_instr"}, out_instr, 32'd0);
        chk({tag, "_err_illegal"}, 32'(err_illegal), 32'd0);
        chk({tag, "_err_range"}, 32'(err_range), 32'd0);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_s_out_addr"}, 32'(s_out_addr), 32'd0);
    endtask

    initial begin
        bit acc;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_op = '0; in_rd = '0; in_rn = '0; in_rm = '0; in_imm = '0;
        repeat (3) @(posedge clock);
        #1;
        check_reset_values("rst");
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;

        send(0, 1, 2, 3, 0);
        chk("add_word", out_instr, 32'h8B030041);
        chk("add_addr", 32'(out_addr), 32'd0);

        send(7, 5, 6, 0, 8);
        chk("ldur_word", out_instr, 32'hF84080C5);
        send(7, 5, 6, 0, 300);
        chk("ldur_imm9", 32'(out_instr[20:12]), 32'h12C);
        idle(2);

        send(10, 9, 0, 0, -2);
        chk("cbz_word", out_instr, 32'hB4FFFFC9);
        idle(5);

        // Backpressure with a request waiting
        send(1, 4, 5, 6, 0);
        out_ready = 1'b0;
        in_valid = 1'b1; in_op = 4'd3; in_rd = 5'd7; in_rn = 5'd8; in_rm = 5'd9; in_imm = '0;
        repeat (5) begin
            cycle(acc);
            chk("stall_no_accept", 32'(acc), 32'd0);
        end
        out_ready = 1'b1;
        cycle(acc);
        chk("stall_release_accept", 32'(acc), 32'd1);
        in_valid = 1'b0;
        idle(2);

        send(15, 0, 0, 0, 0);
        send(4, 1, 1, 1, 0);
        send(5, 2, 3, 0, 64);
        idle(3);

        // Asynchronous reset while the second pad NOP is being presented
        send(12, 0, 0, 0, 100);
        idle(2);
        @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        check_reset_values("midpad");
        exp_q.delete(); exp_addr = 0; exp_addr_s = 0; exp_ill = 0; exp_rng = 0;
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;

        for (int i = 0; i < 5; i++) begin
            send(0, i, i + 1, i + 2, 0);
        end
        idle(3);

        for (int i = 0; i < 400; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = ($urandom_range(0, 2) != 0);
            in_op = 4'($urandom_range(0, 15));
            in_rd = 5'($urandom); in_rn = 5'($urandom); in_rm = 5'($urandom);
            if ($urandom_range(0, 1) == 0) in_imm = 26'($urandom_range(0, 800)) - 26'd400;
            else in_imm = 26'($urandom);
            cycle(acc);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        idle(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

- Streaming LEGv8 instruction encoder: accepts operation requests (op class, register numbers, immediate) over a valid/ready handshake.
- Emits 32-bit instruction words, each tagged with a word-aligned instruction-memory address.
- Inserts a parameterised number of NOP fill slots after every branch, so the pipelined core never needs a flush.
- Sits between the test/boot loader and the instruction-memory write port. It is the producing end of the opcode field that `control` consumes.

## Interface
Parameters:
- ADDR_W, 10, width of out_addr (byte address, wraps modulo 2^ADDR_W)
- BASE_ADDR, 0, address of first emitted word (multiple of 4)
- BR_PAD, 3, NOP words inserted after each B/BL/CBZ/CBNZ/BR (0..15)

Ports (one clock; reset is asynchronous and active-high):
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- in_valid  in  1  request present
- in_ready  out  1  request accepted when in_valid && in_ready
- in_op  in  4  op class (package enum)
- in_rd  in  5  Rd / Rt
- in_rn  in  5  Rn
- in_rm  in  5  Rm
- in_imm  in  26  signed immediate (shamt for LSL/LSR, unsigned)
- out_valid  out  1  out_instr/out_addr valid
- out_ready  in  1  consumer accepts when out_valid && out_ready
- out_instr  out  32  encoded word
- out_addr  out  ADDR_W  byte address of out_instr
- err_illegal  out  1  sticky: illegal op received
- err_range  out  1  sticky: immediate did not fit its field

## Operation
- Op classes and formats, with opcode bits placed from [31] down:
  - OP_ADD=0, SUB=1, AND=2, ORR=3, EOR=4: R-format. Opcodes 10001011000, 11001011000, 10001010000, 10101010000, 11001010000. Fields: Rm[20:16], shamt[15:10]=0, Rn[9:5], Rd[4:0].
  - OP_LSL=5 (11010011011), OP_LSR=6 (11010011010): R-format. Rm=0, shamt=in_imm[5:0]. err_range if in_imm > 63 (unsigned).
  - OP_LDUR=7 (11111000010), OP_STUR=8 (11111000000): D-format. Fields: imm9[20:12], [11:10]=00, Rn[9:5], Rt[4:0]. err_range unless -256 ≤ imm ≤ 255.
  - OP_BR=9 (11010110000): Rn[9:5]; all other fields 0.
  - OP_CBZ=10 (10110100), OP_CBNZ=11 (10110101): CB-format. Fields: imm19[23:5], Rt[4:0]. err_range unless the value fits 19-bit signed.
  - OP_B=12 (000101), OP_BL=13 (100101): imm26[25:0]. Always in range.
  - 14, 15 are illegal.
- On range error: field = imm truncated to field width. The word is still emitted and err_range is set.
- Illegal op:
  - Accepted (consumed) and not emitted.
  - err_illegal is set; out_addr is unchanged.
- NOP = ADD XZR,XZR,XZR = 0x8B1F03FF.
- FSM, two states:
  - IDLE: in_ready = !out_valid || out_ready.
    - A legal accept loads the output register.
    - A branch op (9..13) with BR_PAD>0 also loads pad_cnt=BR_PAD and moves to PAD.
  - PAD: in_ready=0.
    - Each cycle with (!out_valid || out_ready): load NOP, decrement pad_cnt.
    - The load with pad_cnt==1 returns to IDLE.
- out_addr: increments by 4 on each output handshake; wraps to 0 after 2^ADDR_W-4. Applies to NOPs as well.
- Sticky errors clear only on reset.

## Timing
- Reset values:
  - out_valid=0, out_instr=0, out_addr=BASE_ADDR
  - err_illegal=0, err_range=0
  - FSM=IDLE, pad_cnt=0
  - in_ready=1 (combinational)
- Latency: accept in cycle N → out_valid=1 in cycle N+1 with the encoded word. Full throughput of 1 word/cycle when out_ready=1.
- Backpressure: while out_valid && !out_ready, out_instr and out_addr hold stable and in_ready=0.
- Simultaneous output handshake and new accept in the same cycle: the register reloads with no bubble, and out_addr advances by 4.
- Branch with BR_PAD=3 and out_ready=1: branch word at N+1, NOPs at N+2..N+4, in_ready=1 again in cycle N+4.
- Errors assert in the cycle after the offending accept.
- Reset mid-PAD or mid-stall:
  - Remaining NOPs and the held word are discarded.
  - All outputs return to their reset values immediately (asynchronous).

## Structure
- Package `legv8_pkg`: the op_t enum (4 bits), the 11/8/6-bit opcode constants (shared with `control`), NOP_WORD, and field-position localparams.
- One sub-module, `instr_field_pack`: combinational op + fields → {word, range_err, illegal}.
- The top level holds the FSM, pad counter, output register and address counter.

## Test plan
- ADD rd=1 rn=2 rm=3, out_ready=1 → out_instr=0x8B030041, out_addr=0x000, one cycle after accept.
- LDUR rd=5 rn=6 imm=8 → 0xF84080C5. Then LDUR imm=300 → imm9 field=0x12C and err_range=1 (sticky).
- CBZ rd=9 imm=-2, BR_PAD=3 → 0xB4FFFFC9 @0, then 0x8B1F03FF @4, 8, 12. in_ready=0 throughout padding.
- out_ready low for 5 cycles mid-stream → out_instr and out_addr stable, in_ready=0, no word lost or duplicated.
- in_op=15 → nothing emitted, err_illegal=1, the next legal word takes the unchanged address. Also: ADDR_W=4 with 5 words emitted → addresses 0, 4, 8, 12, 0.
- Assert reset during the 2nd pad NOP → out_valid=0 and out_addr=BASE_ADDR at once. After release, the next request encodes normally at BASE_ADDR.
